io_mem_responder: RTL



---
 rtl/io_map_pkg.sv | 10 +
 rtl/btn_debouncer.sv | 41 ++++
 rtl/io_mem_responder.sv | 85 ++++++++
 3 files changed

// File: rtl/io_map_pkg.sv
// Register window layout and sizing shared by the I/O responder and its bench.
package io_map_pkg;
    localparam logic [3:0] PRESS_OFS = 4'h0;
    localparam logic [3:0] LEVEL_OFS = 4'h4;
    localparam logic [3:0] LED_OFS   = 4'h8;
    localparam logic [3:0] TICKS_OFS = 4'hC;

    localparam int unsigned NUM_BTNS  = 2;
    localparam int unsigned LED_WIDTH = 16;
endpackage

// File: rtl/btn_debouncer.sv
// Two-flop synchronizer plus stability counter for one push button.
// rise is a registered one-cycle pulse issued together with a 0->1 level change.
module btn_debouncer #(
    parameter int unsigned DEBOUNCE_CYCLES = 1000
) (
    input  logic clk_in,
    input  logic rst_in,
    input  logic btn,
    output logic level,
    output logic rise
);
    localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync1, sync2;
    logic [CW-1:0] cnt;

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            cnt   <= '0;
            level <= 1'b0;
            rise  <= 1'b0;
        end else begin
            sync1 <= btn;
            sync2 <= sync1;
            rise  <= 1'b0;
            // Count only while the synced input disagrees with the accepted level.
            if (sync2 == level) begin
                cnt <= '0;
            end else if (cnt == LAST) begin
                cnt   <= '0;
                level <= sync2;
                rise  <= sync2;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end
endmodule

// File: rtl/io_mem_responder.sv
// Memory-mapped responder: PRESS/LEVEL/LED/TICKS registers at BASE_ADDR,
// single-cycle read latency, bus_err on misaligned or simultaneous accesses.
module io_mem_responder
    import io_map_pkg::*;
#(
    parameter int unsigned            ADDR_WIDTH      = 32,
    parameter int unsigned            DATA_WIDTH      = 32,
    parameter logic [ADDR_WIDTH-1:0]  BASE_ADDR       = 32'h0000_F000,
    parameter int unsigned            DEBOUNCE_CYCLES = 1000
) (
    input  logic                  clk_in,
    input  logic                  rst_in,
    input  logic [NUM_BTNS-1:0]   debug_btns,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] write_data,
    input  logic                  dispatch_read,
    input  logic                  dispatch_write,
    output logic [DATA_WIDTH-1:0] read_data,
    output logic                  read_valid,
    output logic                  bus_err,
    output logic [LED_WIDTH-1:0]  led_out
);
    logic [NUM_BTNS-1:0]   level, rise, press, w1c;
    logic [31:0]           ticks;
    logic [ADDR_WIDTH-1:0] ofs;
    logic                  in_win, aligned, hit_wr;
    logic [DATA_WIDTH-1:0] rd_mux;
    logic                  unused_wdata;

    for (genvar i = 0; i < NUM_BTNS; i++) begin : g_btn
        btn_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb (
            .clk_in (clk_in),
            .rst_in (rst_in),
            .btn    (debug_btns[i]),
            .level  (level[i]),
            .rise   (rise[i])
        );
    end

    assign ofs          = addr - BASE_ADDR;
    assign in_win       = (addr >= BASE_ADDR) && (ofs < ADDR_WIDTH'(16));
    assign aligned      = (addr[1:0] == 2'b00);
    assign hit_wr       = in_win && aligned && dispatch_write;
    assign w1c          = (hit_wr && ofs[3:0] == PRESS_OFS) ? write_data[NUM_BTNS-1:0] : '0;
    assign unused_wdata = ^write_data;

    always_comb begin
        rd_mux = '0;
        case (ofs[3:0])
            PRESS_OFS: rd_mux = DATA_WIDTH'(press);
            LEVEL_OFS: rd_mux = DATA_WIDTH'(level);
            LED_OFS:   rd_mux = DATA_WIDTH'(led_out);
            TICKS_OFS: rd_mux = DATA_WIDTH'(ticks);
            default:   rd_mux = '0;
        endcase
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            read_data  <= '0;
            read_valid <= 1'b0;
            bus_err    <= 1'b0;
            led_out    <= '0;
            press      <= '0;
            ticks      <= '0;
        end else begin
            read_valid <= in_win && dispatch_read;
            bus_err    <= in_win && (aligned ? (dispatch_read && dispatch_write)
                                             : (dispatch_read || dispatch_write));
            if (in_win && dispatch_read)
                read_data <= aligned ? rd_mux : '0;

            // A rise in the same cycle as its W1C wins over the clear.
            press <= (press & ~w1c) | rise;

            if (hit_wr && ofs[3:0] == LED_OFS)
                led_out <= write_data[LED_WIDTH-1:0];

            if (hit_wr && ofs[3:0] == TICKS_OFS)
                ticks <= '0;
            else
                ticks <= ticks + 32'd1;
        end
    end
endmodule
